id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register of the RV32I core, sitting directly upstream of the ALU.
- Captures one decoded instruction per valid/ready handshake and holds it.
- Presents forwarded operands plus the ALU select code to the ALU (rs1/rs2/ALUsel inputs).
- Resolves EX/MEM and MEM/WB data hazards by forwarding, and stalls on load-use hazards.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  decode offers an instruction
in_ready  output  1  stage can accept this cycle
in_rs1_addr  input  RA_W  source register 1 index
in_rs2_addr  input  RA_W  source register 2 index
in_rs1_used  input  1  instruction reads rs1
in_rs2_used  input  1  instruction reads rs2
in_rs1_data  input  XLEN  register-file read data 1
in_rs2_data  input  XLEN  register-file read data 2
in_imm  input  XLEN  generated immediate
in_use_imm  input  1  ALU operand 2 = immediate
in_alu_sel  input  4  ALU operation code
in_rd_addr  input  RA_W  destination index
in_reg_write  input  1  instruction writes rd
in_is_load  input  1  instruction is a load
flush  input  1  kill held instruction (branch redirect)
mem_fwd_valid  input  1  EX/MEM holds a register-writing instruction
mem_fwd_rd  input  RA_W  its rd
mem_fwd_data  input  XLEN  its ALU result
mem_fwd_is_load  input  1  its data is not yet available
wb_fwd_valid  input  1  MEM/WB writes the register file this cycle
wb_fwd_rd  input  RA_W  writeback rd
wb_fwd_data  input  XLEN  writeback data
out_ready  input  1  execute stage accepts
out_valid  output  1  operands valid and hazard-free
alu_rs1  output  XLEN  ALU operand 1
alu_rs2  output  XLEN  ALU operand 2 (forwarded rs2 or imm)
alu_sel  output  4  ALU operation code
out_store_data  output  XLEN  forwarded rs2 value
out_rd_addr  output  RA_W  destination index
out_reg_write  output  1  write-enable for rd
out_is_load  output  1  load flag

Behaviour:
- State: one-entry buffer, flag full (EMPTY/FULL).
- Reset: full=0 and all stored fields cleared. Outputs then read out_valid=0, alu_rs1=0, alu_rs2=0, alu_sel=0, out_store_data=0, out_rd_addr=0, out_reg_write=0, out_is_load=0.
- Reset overrides flush and in_valid.
- hazard: full & mem_fwd_valid & mem_fwd_is_load & mem_fwd_rd!=0 & ((rs1_used & mem_fwd_rd==rs1_addr) | (rs2_used & mem_fwd_rd==rs2_addr)).
- out_valid = full & ~hazard.
- in_ready = ~full | (out_valid & out_ready).
- Accept when in_valid & in_ready: all fields registered, full=1. Latency: out_valid can assert the cycle after acceptance.
- Fire (out_valid & out_ready) without accept: full=0. Fire and accept in the same cycle: the new instruction replaces the old one, full stays 1, giving back-to-back throughput of 1 per cycle.
- flush: full=0 next cycle, overriding both accept and hold. in_ready is unaffected by flush.
- Operand forwarding, per source operand x (combinational from stored fields):
  - addr==0 gives 0.
  - Else mem_fwd_valid & ~mem_fwd_is_load & mem_fwd_rd==addr gives mem_fwd_data.
  - Else wb_fwd_valid & wb_fwd_rd==addr gives wb_fwd_data.
  - Else the stored data.
  - EX/MEM has priority over MEM/WB.
- alu_rs2 = stored use_imm ? stored imm : forwarded rs2.
- out_store_data = forwarded rs2, always.
- Stale capture: while full and not replaced, if wb_fwd_valid & wb_fwd_rd!=0 matches stored rs1_addr (or rs2_addr), the stored data is overwritten with wb_fwd_data. This means held operands survive writeback retiring during stalls.
- Accept-cycle writeback: on the accept cycle, if WB writes an in_rs* register, store wb_fwd_data instead of in_rs*_data (register-file write/read collision).
- Held stall: while out_valid=0 or out_ready=0, all outputs other than the forwarded operands stay stable.

Test Plan:
- Reset mid-operation: with full=1 holding an instruction, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, all outputs 0.
- EX/MEM forwarding: accept add x3,x1,x2 (rs1_data=5, rs2_data=7, alu_sel=0000) with mem_fwd_valid=1, mem_fwd_rd=1, mem_fwd_data=100 -> alu_rs1=100, alu_rs2=7, out_valid=1 one cycle after accept.
- Forward priority and x0: mem and wb both target rd=2 (mem data 0x11, wb data 0x22) -> alu_rs2=0x11. With rs1_addr=0 and mem_fwd_rd=0, data 0xFF -> alu_rs1=0.
- Load-use stall: held instruction with rs1=4 while mem_fwd_is_load=1, mem_fwd_rd=4 -> out_valid=0, in_ready=0. Next cycle load retires via wb_fwd_rd=4, data 0xABCD and mem_fwd_valid=0 -> out_valid=1, alu_rs1=0xABCD. Operand is still 0xABCD after wb_fwd_valid drops.
- Backpressure and throughput: out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then stream 4 instructions with out_ready=1 -> 4 fires in 4 consecutive cycles, in order.
- Flush priority: flush=1 together with in_valid=1 and in_ready=1 -> next cycle out_valid=0, instruction dropped.

Source files
------------

// File: rtl/id_ex_operand_if.sv
// Decode-to-execute bundle: decode offer, forwarding taps, ALU-side result.
// slave is the stage itself, master is whoever drives it.
interface id_ex_operand_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [RA_W-1:0] in_rs1_addr;
    logic [RA_W-1:0] in_rs2_addr;
    logic            in_rs1_used;
    logic            in_rs2_used;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic [3:0]      in_alu_sel;
    logic [RA_W-1:0] in_rd_addr;
    logic            in_reg_write;
    logic            in_is_load;
    logic            flush;
    logic            mem_fwd_valid;
    logic [RA_W-1:0] mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            mem_fwd_is_load;
    logic            wb_fwd_valid;
    logic [RA_W-1:0] wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] out_store_data;
    logic [RA_W-1:0] out_rd_addr;
    logic            out_reg_write;
    logic            out_is_load;

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_used, in_rs2_used,
        input  in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_alu_sel,
        input  in_rd_addr, in_reg_write, in_is_load, flush,
        input  mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load,
        input  wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
        output in_ready, out_valid, alu_rs1, alu_rs2, alu_sel,
        output out_store_data, out_rd_addr, out_reg_write, out_is_load
    );

    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_used, in_rs2_used,
        output in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_alu_sel,
        output in_rd_addr, in_reg_write, in_is_load, flush,
        output mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load,
        output wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
        input  in_ready, out_valid, alu_rs1, alu_rs2, alu_sel,
        input  out_store_data, out_rd_addr, out_reg_write, out_is_load
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register: one-entry buffer with EX/MEM + MEM/WB forwarding
// and load-use stall in front of the ALU.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic             clk,
    input logic             rst,
    id_ex_operand_if.slave  bus
);
    typedef struct packed {
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic            rs1_used;
        logic            rs2_used;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [3:0]      alu_sel;
        logic [RA_W-1:0] rd_addr;
        logic            reg_write;
        logic            is_load;
    } id_ex_t;

    id_ex_t q;
    id_ex_t nxt;
    logic   full;
    logic   hazard;
    logic   fire;
    logic   accept;
    logic   cap1;
    logic   cap2;
    logic   mem_hit1;
    logic   mem_hit2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    function automatic logic [XLEN-1:0] fwd(
        input logic [RA_W-1:0] a,
        input logic [XLEN-1:0] d,
        input logic            mv,
        input logic            ml,
        input logic [RA_W-1:0] mr,
        input logic [XLEN-1:0] md,
        input logic            wv,
        input logic [RA_W-1:0] wr,
        input logic [XLEN-1:0] wd
    );
        logic [XLEN-1:0] r;
        if (a == '0)
            r = '0;
        else if (mv && !ml && mr == a)
            r = md;
        else if (wv && wr == a)
            r = wd;
        else
            r = d;
        return r;
    endfunction

    assign mem_hit1 = q.rs1_used && bus.mem_fwd_rd == q.rs1_addr;
    assign mem_hit2 = q.rs2_used && bus.mem_fwd_rd == q.rs2_addr;

    // A load in EX/MEM has no data yet; anything reading its rd must wait.
    assign hazard = full && bus.mem_fwd_valid && bus.mem_fwd_is_load
                    && bus.mem_fwd_rd != '0 && (mem_hit1 || mem_hit2);

    assign bus.out_valid = full && !hazard;
    assign fire          = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = !full || fire;
    assign accept        = bus.in_valid && bus.in_ready;

    assign fwd1 = fwd(q.rs1_addr, q.rs1_data,
                      bus.mem_fwd_valid, bus.mem_fwd_is_load,
                      bus.mem_fwd_rd, bus.mem_fwd_data,
                      bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign fwd2 = fwd(q.rs2_addr, q.rs2_data,
                      bus.mem_fwd_valid, bus.mem_fwd_is_load,
                      bus.mem_fwd_rd, bus.mem_fwd_data,
                      bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);

    assign bus.alu_rs1        = fwd1;
    assign bus.alu_rs2        = q.use_imm ? q.imm : fwd2;
    assign bus.out_store_data = fwd2;
    assign bus.alu_sel        = q.alu_sel;
    assign bus.out_rd_addr    = q.rd_addr;
    assign bus.out_reg_write  = q.reg_write;
    assign bus.out_is_load    = q.is_load;

    assign cap1 = bus.wb_fwd_valid && bus.wb_fwd_rd != '0
                  && bus.wb_fwd_rd == q.rs1_addr;
    assign cap2 = bus.wb_fwd_valid && bus.wb_fwd_rd != '0
                  && bus.wb_fwd_rd == q.rs2_addr;

    // Register file is written and read in the same cycle: take WB data.
    always_comb begin
        nxt           = '0;
        nxt.rs1_addr  = bus.in_rs1_addr;
        nxt.rs2_addr  = bus.in_rs2_addr;
        nxt.rs1_used  = bus.in_rs1_used;
        nxt.rs2_used  = bus.in_rs2_used;
        nxt.rs1_data  = bus.in_rs1_data;
        nxt.rs2_data  = bus.in_rs2_data;
        nxt.imm       = bus.in_imm;
        nxt.use_imm   = bus.in_use_imm;
        nxt.alu_sel   = bus.in_alu_sel;
        nxt.rd_addr   = bus.in_rd_addr;
        nxt.reg_write = bus.in_reg_write;
        nxt.is_load   = bus.in_is_load;
        if (bus.wb_fwd_valid && bus.wb_fwd_rd == bus.in_rs1_addr)
            nxt.rs1_data = bus.wb_fwd_data;
        if (bus.wb_fwd_valid && bus.wb_fwd_rd == bus.in_rs2_addr)
            nxt.rs2_data = bus.wb_fwd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (bus.flush) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
            q    <= nxt;
        end else if (fire) begin
            full <= 1'b0;
        end else if (full) begin
            // Keep held operands current while stalled across a writeback.
            if (cap1)
                q.rs1_data <= bus.wb_fwd_data;
            if (cap2)
                q.rs2_data <= bus.wb_fwd_data;
        end
    end
endmodule
